uart_rx: RTL and testbench
==========================

# uart_rx

UART serial receiver for the communication module. Consumes the 16x-oversampling enable `s_tick` from the sample-tick generator and the raw `rx` line, and recovers 8-N-1 frames (LSB first). It delivers each received byte with a one-cycle strobe to the downstream command/AES interface logic. `s_tick` is a clock enable only; the block runs entirely on `clk`.

## Interface
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: `s_tick` count for the stop bit (16 = 1 stop bit).
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `s_tick` input 1: oversampling enable, 16 pulses per bit period, each one `clk` wide.
- `rx` input 1: asynchronous serial line, idle high.
- `dout` output DBIT: last received byte. Held until the next completed frame.
- `rx_done_tick` output 1: one-cycle strobe; `dout` is valid in the same cycle.
- `frame_err` output 1: one-cycle pulse coincident with `rx_done_tick`, set when the stop bit sampled low.
- `parity_err` output 1: exists only with `UART_RX_PARITY_EN`; one-cycle pulse coincident with `rx_done_tick`.

## Operation
- `rx` passes through a 2-flop synchronizer; all sampling uses the synchronized `rx_s`.
- Internal registers:
  - state
  - `s`: 4-bit tick counter
  - `n`: bit counter, `$clog2(DBIT)` bits
  - `b`: DBIT-bit shift register
- FSM states:
  - IDLE:
    - Entered when `rx_s`=0: go to START with `s`=0. This does not wait for `s_tick`.
  - START, counting on `s_tick`:
    - At `s`=7 (mid start bit), if `rx_s`=0: go to DATA with `s`=0, `n`=0.
    - At `s`=7, if `rx_s`=1: false start; return to IDLE with no strobe.
  - DATA:
    - On `s_tick` at `s`=15: `b` <= {`rx_s`, `b`[DBIT-1:1]}, `s`=0.
    - If `n`=DBIT-1, go to PARITY (with macro) or STOP. Otherwise `n`++.
  - PARITY (macro only):
    - On `s_tick` at `s`=15: latch `rx_s` XOR (^`b`) as the parity mismatch (even parity), then go to STOP with `s`=0.
  - STOP:
    - On `s_tick` at `s`=SB_TICK-1: `dout` <= `b`, `rx_done_tick` <= 1, `frame_err` <= ~`rx_s`, `parity_err` <= mismatch.
    - Then return to IDLE.
- The `s` counter wraps naturally at 16. It resets to 0 on every state transition.
- Frames with errors still deliver `dout` and the strobe; downstream decides whether to discard.
- No `s_tick` means no progress. The FSM holds its state indefinitely.

## Timing
- Reset values:
  - state IDLE
  - `s`, `n`, `b` = 0
  - synchronizer flops = 1 (idle line)
  - `dout` = 0
  - `rx_done_tick`, `frame_err`, `parity_err` = 0
- Reset asserted mid-frame aborts immediately. There is no strobe for the partial frame.
- Input latency is 2 `clk` from `rx` to `rx_s`.
- All outputs are registered. `rx_done_tick` is high exactly one `clk`, on the edge following the final stop-bit `s_tick`.
- Each sample point is mid-bit: START ends at tick 8 of the start bit, and each later bit adds 16 ticks.
- Back-to-back frames:
  - IDLE can detect the next start bit in the `clk` after the STOP exit.
  - The stop bit must last at least SB_TICK/2 ticks past the sample point; this is guaranteed at nominal baud.
- If `rx_done_tick` and a new falling edge occur in the same cycle, both are honoured: the strobe fires and START begins.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state and the `parity_err` port are present.
  - Frame is 8-E-1.
- `UART_RX_PARITY_EN` undefined:
  - Frame is 8-N-1.
  - No PARITY state and no `parity_err` port.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - `OVERSAMPLE`=16
  - `MID_TICK`=7
  - default DBIT/SB_TICK constants, shared with the future `uart_tx`
- Sub-module `uart_rx_sync`: parameterised 2-flop synchronizer with reset value 1, reused by other async inputs.

## Test plan
Bench drives `s_tick` every 4 `clk` for speed; one bit = 64 `clk`.
- Frame 0xA5 with stop bit high -> exactly one `rx_done_tick`, `dout`=0xA5, `frame_err`=0.
- Frame 0x3C with stop bit driven low -> `rx_done_tick` with `dout`=0x3C, `frame_err`=1 in the same cycle.
- 3-tick low glitch on idle `rx` -> returns to IDLE, no `rx_done_tick`, `dout` unchanged.
- Back-to-back 0x00 then 0xFF with no idle gap -> two strobes, `dout` 0x00 then 0xFF, no errors.
- `reset` pulsed during data bit 3 of a frame, then frame 0x5A -> all outputs 0 during and after reset, no strobe for the aborted frame, then `dout`=0x5A.
- With `UART_RX_PARITY_EN`: 0x81 sent with parity bit 1 -> `parity_err`=1. Same byte with parity bit 0 -> `parity_err`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and
// default frame geometry, common to uart_rx and the future uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  localparam int OVERSAMPLE      = 16;
  localparam int MID_TICK        = 7;
  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Parameterised 2-flop synchronizer for asynchronous inputs; both stages reset
// to RESET_VAL (all ones by default, matching an idle UART line).
module uart_rx_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, 8-N-1 by default; defining UART_RX_PARITY_EN
// adds an even-parity bit (8-E-1) and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int             NW     = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [3:0]     MID_S  = 4'(MID_TICK);
  localparam logic [3:0]     LAST_S = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]     STOP_S = 4'(SB_TICK - 1);
  localparam logic [NW-1:0]  LAST_N = NW'(DBIT - 1);

  logic rx_s;

  uart_rx_sync #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  uart_rx_state_e  state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic            pmis_q, pmis_d;
  logic            perr_q, perr_d;
`endif

  // The tick counter is cleared on every state change so each state starts
  // counting from the beginning of its own bit window.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pmis_d  = pmis_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == MID_S) begin
            s_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == LAST_S) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == LAST_N) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == LAST_S) begin
            s_d     = '0;
            pmis_d  = rx_s ^ (^b_q);
            state_d = STOP;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == STOP_S) begin
            s_d     = '0;
            state_d = IDLE;
            dout_d  = b_q;
            done_d  = 1'b1;
            ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = pmis_q;
`endif
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pmis_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pmis_q  <= pmis_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: s_tick every 4 clk (64 clk per bit), directed
// scenarios plus random frames checked against a frame-level reference model.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick;
  logic [1:0] tick_div = 2'd0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rx_frame_t;

  rx_frame_t got_q[$];
  rx_frame_t mon_f;
  int        long_strobe = 0;
  logic      done_prev = 1'b0;

  uart_rx #(
    .DBIT   (8),
    .SB_TICK(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx          (rx),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) tick_div <= tick_div + 2'd1;
  assign s_tick = (tick_div == 2'd3);

  // Capture every delivered frame; a strobe lasting more than one clk is counted.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      mon_f.data = dout;
      mon_f.ferr = frame_err;
`ifdef UART_RX_PARITY_EN
      mon_f.perr = parity_err;
`else
      mon_f.perr = 1'b0;
`endif
      got_q.push_back(mon_f);
      if (done_prev) long_strobe++;
    end
    done_prev = rx_done_tick;
  end

  task automatic drive_bit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // A bad stop bit is held low past its sample point, then the line idles long
  // enough that the receiver's re-triggered start check sees a high line.
  task automatic drive_frame(input logic [8:0] payload, input int nbits, input logic stop_ok);
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < nbits; i++) drive_bit(payload[i], BIT_CLK);
    if (stop_ok) begin
      drive_bit(1'b1, BIT_CLK);
    end else begin
      drive_bit(1'b0, 40);
      drive_bit(1'b1, 88);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_ok);
`ifdef UART_RX_PARITY_EN
    drive_frame({1'(($countones(data) % 2) == 1), data}, 9, stop_ok);
`else
    drive_frame({1'b0, data}, 8, stop_ok);
`endif
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] data, input logic par_bit);
    drive_frame({par_bit, data}, 9, 1'b1);
  endtask
`endif

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++; if (dout !== 8'h00) $display("[TB] FAIL reset_dout: got %h expected %h", dout, 8'h00); else pass_cnt++;
    check_cnt++; if (rx_done_tick !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", rx_done_tick); else pass_cnt++;
    check_cnt++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_ferr: got %b expected 0", frame_err); else pass_cnt++;
`ifdef UART_RX_PARITY_EN
    check_cnt++; if (parity_err !== 1'b0) $display("[TB] FAIL reset_perr: got %b expected 0", parity_err); else pass_cnt++;
`endif
    reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_good_frame();
    got_q.delete();
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check_cnt++; if (got_q.size() !== 1) $display("[TB] FAIL good_count: got %0d expected 1", got_q.size()); else pass_cnt++;
    if (got_q.size() >= 1) begin
      check_cnt++; if (got_q[0].data !== 8'hA5) $display("[TB] FAIL good_dout: got %h expected a5", got_q[0].data); else pass_cnt++;
      check_cnt++; if (got_q[0].ferr !== 1'b0) $display("[TB] FAIL good_ferr: got %b expected 0", got_q[0].ferr); else pass_cnt++;
    end
    check_cnt++; if (dout !== 8'hA5) $display("[TB] FAIL good_hold: got %h expected a5", dout); else pass_cnt++;
    check_cnt++; if (rx_done_tick !== 1'b0) $display("[TB] FAIL good_strobe_low: got %b expected 0", rx_done_tick); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    got_q.delete();
    send_frame(8'h3C, 1'b0);
    repeat (100) @(negedge clk);
    check_cnt++; if (got_q.size() !== 1) $display("[TB] FAIL ferr_count: got %0d expected 1", got_q.size()); else pass_cnt++;
    if (got_q.size() >= 1) begin
      check_cnt++; if (got_q[0].data !== 8'h3C) $display("[TB] FAIL ferr_dout: got %h expected 3c", got_q[0].data); else pass_cnt++;
      check_cnt++; if (got_q[0].ferr !== 1'b1) $display("[TB] FAIL ferr_flag: got %b expected 1", got_q[0].ferr); else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    got_q.delete();
    drive_bit(1'b0, 12);
    drive_bit(1'b1, 300);
    check_cnt++; if (got_q.size() !== 0) $display("[TB] FAIL glitch_count: got %0d expected 0", got_q.size()); else pass_cnt++;
    check_cnt++; if (dout !== 8'h3C) $display("[TB] FAIL glitch_dout: got %h expected 3c", dout); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    check_cnt++; if (got_q.size() !== 2) $display("[TB] FAIL b2b_count: got %0d expected 2", got_q.size()); else pass_cnt++;
    if (got_q.size() >= 2) begin
      check_cnt++; if (got_q[0].data !== 8'h00) $display("[TB] FAIL b2b_first: got %h expected 00", got_q[0].data); else pass_cnt++;
      check_cnt++; if (got_q[1].data !== 8'hFF) $display("[TB] FAIL b2b_second: got %h expected ff", got_q[1].data); else pass_cnt++;
      check_cnt++; if ((got_q[0].ferr | got_q[1].ferr) !== 1'b0) $display("[TB] FAIL b2b_ferr: got %b%b expected 00", got_q[0].ferr, got_q[1].ferr); else pass_cnt++;
    end
    check_cnt++; if (long_strobe !== 0) $display("[TB] FAIL strobe_width: got %0d long strobes expected 0", long_strobe); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] data;
    data = 8'h5A;
    got_q.delete();
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) drive_bit(data[i], BIT_CLK);
    drive_bit(data[3], BIT_CLK / 2);
    reset = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check_cnt++; if ({dout, rx_done_tick, frame_err} !== 10'd0) $display("[TB] FAIL midrst_during: got %h/%b/%b expected 00/0/0", dout, rx_done_tick, frame_err); else pass_cnt++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check_cnt++; if (got_q.size() !== 0) $display("[TB] FAIL midrst_nostrobe: got %0d expected 0", got_q.size()); else pass_cnt++;
    check_cnt++; if (dout !== 8'h00) $display("[TB] FAIL midrst_after: got %h expected 00", dout); else pass_cnt++;
    send_frame(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check_cnt++; if (got_q.size() !== 1) $display("[TB] FAIL midrst_count: got %0d expected 1", got_q.size()); else pass_cnt++;
    check_cnt++; if (dout !== 8'h5A) $display("[TB] FAIL midrst_dout: got %h expected 5a", dout); else pass_cnt++;
  endtask

  // Reference model: each frame yields exactly its byte, frame_err = stop bit low.
  task automatic test_random();
    rx_frame_t exp_q[$];
    rx_frame_t e;
    got_q.delete();
    for (int k = 0; k < 10; k++) begin
      e.data = 8'($urandom);
      e.ferr = ($urandom_range(0, 3) == 0);
      e.perr = 1'b0;
      exp_q.push_back(e);
      send_frame(e.data, !e.ferr);
    end
    repeat (20) @(negedge clk);
    check_cnt++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check_cnt++;
      if (got_q[k].data !== exp_q[k].data || got_q[k].ferr !== exp_q[k].ferr || got_q[k].perr !== exp_q[k].perr)
        $display("[TB] FAIL rand_frame%0d: got %h/%b/%b expected %h/%b/%b", k, got_q[k].data, got_q[k].ferr, got_q[k].perr, exp_q[k].data, exp_q[k].ferr, exp_q[k].perr);
      else pass_cnt++;
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    got_q.delete();
    send_frame_par(8'h81, 1'b1);
    send_frame_par(8'h81, 1'b0);
    repeat (20) @(negedge clk);
    check_cnt++; if (got_q.size() !== 2) $display("[TB] FAIL par_count: got %0d expected 2", got_q.size()); else pass_cnt++;
    if (got_q.size() >= 2) begin
      check_cnt++; if (got_q[0].perr !== 1'b1) $display("[TB] FAIL par_bad: got %b expected 1", got_q[0].perr); else pass_cnt++;
      check_cnt++; if (got_q[1].perr !== 1'b0) $display("[TB] FAIL par_good: got %b expected 0", got_q[1].perr); else pass_cnt++;
      check_cnt++; if (got_q[1].data !== 8'h81) $display("[TB] FAIL par_dout: got %h expected 81", got_q[1].data); else pass_cnt++;
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
